// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared FSM state type, default sizes and redirect field widths
//             for the fetch_unit block (ERR state only with FETCH_BOUND_CHECK_EN)
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int FETCH_MEM_WAIT_DFLT  = 2;
  localparam int FETCH_MEM_BYTES_DFLT = 32;
  localparam int BR_OFF_W             = 16;
  localparam int JMP_TGT_W            = 26;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_VALID = 2'd1
`ifdef FETCH_BOUND_CHECK_EN
    ,
    ST_ERR   = 2'd2
`endif
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// next_pc_calc : combinational next-PC selection (jump > branch > sequential),
//                result is unwrapped; range handling lives in fetch_unit
// Revision     : 1.0
// ============================================================================
`default_nettype none

module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0]          pc,
  input  logic                 branch_taken,
  input  logic [BR_OFF_W-1:0]  branch_offset,
  input  logic                 jump,
  input  logic [JMP_TGT_W-1:0] jump_target,
  output logic [31:0]          pc_plus4,
  output logic [31:0]          next_pc
);

  logic [31:0] br_disp;

  assign pc_plus4 = pc + 32'd4;
  // Word offset sign-extended and scaled to bytes.
  assign br_disp  = {{(30-BR_OFF_W){branch_offset[BR_OFF_W-1]}}, branch_offset, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + br_disp;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC owner and instruction-memory address sequencer with fixed
//              access latency; optional range check via FETCH_BOUND_CHECK_EN
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          MEM_BYTES = FETCH_MEM_BYTES_DFLT,
  parameter int          MEM_WAIT  = FETCH_MEM_WAIT_DFLT,
  parameter logic [31:0] RESET_PC  = 32'h0
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [BR_OFF_W-1:0]  branch_offset,
  input  logic                 jump,
  input  logic [JMP_TGT_W-1:0] jump_target,
  output logic [31:0]          read_address,
  output logic [31:0]          pc_out,
  output logic [31:0]          pc_plus4,
  output logic                 inst_valid
`ifdef FETCH_BOUND_CHECK_EN
  ,
  output logic                 addr_err
`endif
);

  localparam int               CNT_W     = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_WAIT - 1);
  localparam logic [31:0]      ADDR_MASK = 32'(MEM_BYTES - 1);
`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [31:0]      PC_MAX    = 32'(MEM_BYTES - 4);
`endif

  fetch_state_e     state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [31:0]      next_pc;

  next_pc_calc u_next_pc_calc (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_WAIT;
      wait_cnt <= '0;
      pc       <= RESET_PC;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      pc       <= pc_nxt;
    end
  end

  // Address only changes when an unstalled VALID cycle retires the instruction.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    pc_nxt    = pc;
    case (state)
      ST_WAIT: begin
        if (wait_cnt == CNT_LAST) begin
          state_nxt = ST_VALID;
        end else begin
          cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      ST_VALID: begin
        if (!stall) begin
`ifdef FETCH_BOUND_CHECK_EN
          if (next_pc > PC_MAX) begin
            state_nxt = ST_ERR;
          end else begin
            pc_nxt    = next_pc;
            cnt_nxt   = '0;
            state_nxt = ST_WAIT;
          end
`else
          pc_nxt    = next_pc & ADDR_MASK;
          cnt_nxt   = '0;
          state_nxt = ST_WAIT;
`endif
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  assign read_address = pc;
  assign pc_out       = pc;
  assign inst_valid   = (state == ST_VALID);
`ifdef FETCH_BOUND_CHECK_EN
  assign addr_err     = (state == ST_ERR);
`endif

endmodule

`default_nettype wire
